xc_malu_seq: RTL and testbench

- Sequencer and packed-adder responder that drives the multi-cycle MALU datapath engines (mul/divrem/pmul next-state logic).
- Owns the iteration registers `count`, `acc`, `arg_0` and `arg_1`, and latches the engine's `n_*` values every cycle.
- Answers the engine's `padd_*` requests with a combinational packed adder.
- Runs a valid/ready handshake toward the core and returns a registered 64-bit result.

---
 rtl/xc_malu_seq.sv | 173 +++++++++++++++++
 tb/tb_xc_malu_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/xc_malu_seq.sv
// Iteration sequencer and packed-adder responder for the multi-cycle MALU engines.
// Optional RUN-cycle abort is enabled by defining XC_MALU_SEQ_TIMEOUT_EN (parameter TIMEOUT).
module xc_malu_seq (
  input  logic        clock,
  input  logic        resetn,
  input  logic        valid,
  input  logic        flush,
  input  logic        pw_32,
  input  logic        pw_16,
  input  logic        pw_8,
  input  logic        pw_4,
  input  logic        pw_2,
  input  logic [63:0] init_acc,
  input  logic [31:0] init_arg_0,
  input  logic [31:0] init_arg_1,
  output logic [5:0]  count,
  output logic [63:0] acc,
  output logic [31:0] arg_0,
  output logic [31:0] arg_1,
  input  logic [63:0] n_acc,
  input  logic [31:0] n_arg_0,
  input  logic [31:0] n_arg_1,
  input  logic        eng_ready,
  input  logic [63:0] eng_result,
  input  logic [31:0] padd_lhs,
  input  logic [31:0] padd_rhs,
  input  logic        padd_sub,
  input  logic        padd_cin,
  input  logic        padd_cen,
  output logic [31:0] padd_result,
  output logic [31:0] padd_cout,
  output logic [63:0] result,
  output logic        ready,
  output logic        busy,
  output logic        timeout
);

`ifdef XC_MALU_SEQ_TIMEOUT_EN
  parameter int unsigned TIMEOUT = 63;
`endif

  // Handshake: the core holds valid until ready; ready is a one-cycle registered
  // pulse, and valid still high in IDLE afterwards starts a new operation.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  count_q;
  logic [63:0] acc_q;
  logic [31:0] arg_0_q, arg_1_q;
  logic [63:0] result_q;
  logic        ready_q;
  logic        run_timeout;

`ifdef XC_MALU_SEQ_TIMEOUT_EN
  logic timeout_q;
  assign run_timeout = (count_q == 6'(TIMEOUT)) && !eng_ready;
`else
  assign run_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid) state_d = RUN;
      RUN:     if (eng_ready || run_timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == DONE);
    end
  end

`ifdef XC_MALU_SEQ_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (!resetn || flush) timeout_q <= 1'b0;
    else                  timeout_q <= (state_q == RUN) && run_timeout;
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Iteration registers: flush clears them but deliberately leaves result intact.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      count_q  <= '0;
      acc_q    <= '0;
      arg_0_q  <= '0;
      arg_1_q  <= '0;
      result_q <= '0;
    end else if (flush) begin
      count_q <= '0;
      acc_q   <= '0;
      arg_0_q <= '0;
      arg_1_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid) begin
            count_q <= '0;
            acc_q   <= init_acc;
            arg_0_q <= init_arg_0;
            arg_1_q <= init_arg_1;
          end
        end
        RUN: begin
          acc_q   <= n_acc;
          arg_0_q <= n_arg_0;
          arg_1_q <= n_arg_1;
          count_q <= (count_q == 6'd63) ? 6'd63 : count_q + 6'd1;
          if (eng_ready)        result_q <= eng_result;
          else if (run_timeout) result_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign count  = count_q;
  assign acc    = acc_q;
  assign arg_0  = arg_0_q;
  assign arg_1  = arg_1_q;
  assign result = result_q;
  assign ready  = ready_q;
  assign busy   = (state_q != IDLE);

  // Packed adder: elem_lsb marks the bit positions where a new element starts.
  logic [31:0] elem_lsb;
  logic [31:0] rhs_eff;
  logic [31:0] sum;
  logic [31:0] cout_raw;
  logic        carry;

  always_comb begin
    if (pw_32)      elem_lsb = 32'h0000_0001;
    else if (pw_16) elem_lsb = 32'h0001_0001;
    else if (pw_8)  elem_lsb = 32'h0101_0101;
    else if (pw_4)  elem_lsb = 32'h1111_1111;
    else if (pw_2)  elem_lsb = 32'h5555_5555;
    else            elem_lsb = 32'h0000_0001;
  end

  always_comb begin
    rhs_eff  = padd_sub ? ~padd_rhs : padd_rhs;
    sum      = '0;
    cout_raw = '0;
    carry    = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (elem_lsb[i])    carry = padd_cin ^ padd_sub;
      else if (!padd_cen) carry = 1'b0;
      sum[i]      = padd_lhs[i] ^ rhs_eff[i] ^ carry;
      carry       = (padd_lhs[i] & rhs_eff[i]) | (padd_lhs[i] & carry) | (rhs_eff[i] & carry);
      cout_raw[i] = carry;
    end
  end

  assign padd_result = sum;
  assign padd_cout   = padd_cen ? cout_raw : 32'h0;

endmodule

// File: tb/tb_xc_malu_seq.sv
// Directed bench for xc_malu_seq: reset, packed adder, sequencing, flush, timeout/saturation.
module tb_xc_malu_seq;

  logic        clock = 1'b0;
  logic        resetn, valid, flush;
  logic        pw_32, pw_16, pw_8, pw_4, pw_2;
  logic [63:0] init_acc;
  logic [31:0] init_arg_0, init_arg_1;
  logic [5:0]  count;
  logic [63:0] acc;
  logic [31:0] arg_0, arg_1;
  logic [63:0] n_acc;
  logic [31:0] n_arg_0, n_arg_1;
  logic        eng_ready;
  logic [63:0] eng_result;
  logic [31:0] padd_lhs, padd_rhs;
  logic        padd_sub, padd_cin, padd_cen;
  logic [31:0] padd_result, padd_cout;
  logic [63:0] result;
  logic        ready, busy, timeout;

  int errors = 0;
  int checks = 0;

  logic       eng_en;
  logic [5:0] eng_at;
  logic       seen_ready;

  always #5 clock = ~clock;

`ifdef XC_MALU_SEQ_TIMEOUT_EN
  xc_malu_seq #(.TIMEOUT(4)) dut (
`else
  xc_malu_seq dut (
`endif
    .clock(clock), .resetn(resetn), .valid(valid), .flush(flush),
    .pw_32(pw_32), .pw_16(pw_16), .pw_8(pw_8), .pw_4(pw_4), .pw_2(pw_2),
    .init_acc(init_acc), .init_arg_0(init_arg_0), .init_arg_1(init_arg_1),
    .count(count), .acc(acc), .arg_0(arg_0), .arg_1(arg_1),
    .n_acc(n_acc), .n_arg_0(n_arg_0), .n_arg_1(n_arg_1),
    .eng_ready(eng_ready), .eng_result(eng_result),
    .padd_lhs(padd_lhs), .padd_rhs(padd_rhs), .padd_sub(padd_sub),
    .padd_cin(padd_cin), .padd_cen(padd_cen),
    .padd_result(padd_result), .padd_cout(padd_cout),
    .result(result), .ready(ready), .busy(busy), .timeout(timeout)
  );

  // Engine model: simple next-state functions and completion at a chosen count.
  always_comb begin
    n_acc     = acc + 64'd1;
    n_arg_0   = arg_0 ^ 32'h1;
    n_arg_1   = arg_1 + 32'd2;
    eng_ready = eng_en && (count == eng_at);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic adder(input logic [4:0] pw, input logic [31:0] l, input logic [31:0] r,
                       input logic sub, input logic cin, input logic cen);
    {pw_32, pw_16, pw_8, pw_4, pw_2} = pw;
    padd_lhs = l; padd_rhs = r; padd_sub = sub; padd_cin = cin; padd_cen = cen;
    #1;
  endtask

  initial begin
    resetn = 1'b0; valid = 1'b1; flush = 1'b0;
    {pw_32, pw_16, pw_8, pw_4, pw_2} = 5'b0;
    init_acc = 64'h77; init_arg_0 = 32'hA5; init_arg_1 = 32'h5A;
    eng_result = 64'h0; eng_en = 1'b0; eng_at = 6'd0;
    padd_lhs = '0; padd_rhs = '0; padd_sub = 1'b0; padd_cin = 1'b0; padd_cen = 1'b0;
    seen_ready = 1'b0;

    // Reset held two edges with valid high
    tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_acc", acc, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);

    // First accept on the edge after resetn rises
    resetn = 1'b1;
    tick();
    check("acc0_busy", 64'(busy), 64'd1);
    check("acc0_acc", acc, 64'h77);
    check("acc0_arg0", 64'(arg_0), 64'hA5);
    check("acc0_arg1", 64'(arg_1), 64'h5A);
    valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl0_busy", 64'(busy), 64'd0);
    check("fl0_acc", acc, 64'd0);

    // Packed adder vectors (pw bits ordered 32,16,8,4,2)
    adder(5'b10000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    check("add32_sum", 64'(padd_result), 64'h0);
    check("add32_cout", 64'(padd_cout), 64'hFFFF_FFFF);
    adder(5'b00000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    check("addnone_sum", 64'(padd_result), 64'h0);
    check("addnone_cout", 64'(padd_cout), 64'hFFFF_FFFF);
    adder(5'b00100, 32'h0001_0203, 32'h0101_0101, 1'b1, 1'b0, 1'b1);
    check("sub8_sum", 64'(padd_result), 64'hFF00_0102);
    adder(5'b00100, 32'h0001_0203, 32'h0101_0101, 1'b1, 1'b1, 1'b0);
    check("sub8_nocen_cin1", 64'(padd_result), 64'hFEFF_FCFD);
    check("sub8_nocen_cout", 64'(padd_cout), 64'h0);
    adder(5'b00100, 32'h0001_0203, 32'h0101_0101, 1'b1, 1'b0, 1'b0);
    check("sub8_nocen_cin0", 64'(padd_result), 64'hFFFE_FDFC);
    adder(5'b01000, 32'h0001_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    check("add16_sum", 64'(padd_result), 64'h0001_0000);
    adder(5'b00010, 32'h0000_00FF, 32'h0000_0011, 1'b0, 1'b0, 1'b1);
    check("add4_sum", 64'(padd_result), 64'h0);
    check("add4_cout", 64'(padd_cout), 64'h0000_00FF);
    adder(5'b00001, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 1'b0, 1'b1);
    check("add2_sum", 64'(padd_result), 64'h0);

    // Sequence: completion at count 3
    valid = 1'b1; init_acc = 64'd5; init_arg_0 = 32'h10; init_arg_1 = 32'h20;
    eng_en = 1'b1; eng_at = 6'd3; eng_result = 64'h1234;
    tick();
    valid = 1'b0;
    check("seq_count0", 64'(count), 64'd0);
    check("seq_acc0", acc, 64'd5);
    tick(); tick(); tick();
    check("seq_count3", 64'(count), 64'd3);
    check("seq_ready_early", 64'(ready), 64'd0);
    tick();
    check("seq_ready", 64'(ready), 64'd1);
    check("seq_result", result, 64'h1234);
    check("seq_acc", acc, 64'd9);
    check("seq_arg0", 64'(arg_0), 64'h10);
    check("seq_arg1", 64'(arg_1), 64'h28);
    check("seq_timeout", 64'(timeout), 64'd0);
    tick();
    check("seq_ready_off", 64'(ready), 64'd0);
    check("seq_busy_off", 64'(busy), 64'd0);

    // Minimum latency with valid held high through ready: a second op starts
    valid = 1'b1; init_acc = 64'd40; eng_at = 6'd0; eng_result = 64'hBEEF;
    tick();
    tick();
    check("min_ready", 64'(ready), 64'd1);
    check("min_result", result, 64'hBEEF);
    eng_en = 1'b0;
    tick();
    check("b2b_idle", 64'(busy), 64'd0);
    tick();
    check("b2b_accept", 64'(busy), 64'd1);
    check("b2b_acc", acc, 64'd40);
    valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;

    // Flush mid-run at count 10, then a fresh accept
    valid = 1'b1; init_acc = 64'h100;
    tick();
    valid = 1'b0;
    repeat (10) tick();
    check("fl_count10", 64'(count), 64'd10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_busy", 64'(busy), 64'd0);
    check("fl_count", 64'(count), 64'd0);
    check("fl_acc", acc, 64'd0);
    check("fl_ready", 64'(ready), 64'd0);
    check("fl_result_hold", result, 64'hBEEF);
    tick(); tick();
    valid = 1'b1; init_acc = 64'hABC;
    tick();
    valid = 1'b0;
    check("fl_reaccept_busy", 64'(busy), 64'd1);
    check("fl_reaccept_acc", acc, 64'hABC);
    check("fl_reaccept_count", 64'(count), 64'd0);

`ifdef XC_MALU_SEQ_TIMEOUT_EN
    // TIMEOUT=4 with the engine never completing
    repeat (4) tick();
    check("to_ready_early", 64'(ready), 64'd0);
    tick();
    check("to_ready", 64'(ready), 64'd1);
    check("to_timeout", 64'(timeout), 64'd1);
    check("to_result", result, 64'd0);
    tick();
    check("to_ready_off", 64'(ready), 64'd0);
    check("to_timeout_off", 64'(timeout), 64'd0);
    check("to_busy_off", 64'(busy), 64'd0);
`else
    // No timeout: count saturates and no ready ever appears
    for (int i = 0; i < 70; i++) begin
      tick();
      seen_ready = seen_ready | ready;
    end
    check("sat_no_ready", 64'(seen_ready), 64'd0);
    check("sat_count", 64'(count), 64'd63);
    check("sat_busy", 64'(busy), 64'd1);
    check("sat_timeout", 64'(timeout), 64'd0);
    check("sat_acc", acc, 64'hABC + 64'd70);
    flush = 1'b1;
    tick();
    flush = 1'b0;
`endif

    // Flush together with valid in IDLE: request is not taken
    valid = 1'b1; flush = 1'b1;
    tick();
    check("flv_busy", 64'(busy), 64'd0);
    valid = 1'b0; flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
